// File: rtl/aes_pkg.sv
// AES-128 constants, state type and round helper functions shared by the
// CTR encipher top and its combinational round.
package aes_pkg;

    localparam int unsigned Nb = 4;
    localparam int unsigned Nk = 4;
    localparam int unsigned Nr = 10;

    typedef enum logic [1:0] {StIdle, StInit, StRound, StDone} aes_fsm_e;

    // s[3-c][3-r] holds column c, row r, so byte 0 sits at bits [127:120].
    typedef logic [3:0][3:0][7:0] state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [10:1][7:0] RCON = {
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    function automatic logic [7:0] get_rcon(input logic [3:0] rnd);
        return (rnd >= 4'd1 && rnd <= 4'd10) ? RCON[rnd] : 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic state_t sub_bytes(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[c][r] = sbox(s[c][r]);
            end
        end
        return o;
    endfunction

    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[3-c][3-r] = s[3-((c+r)%4)][3-r];
            end
        end
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t     o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[3-c][3];
            a1 = s[3-c][2];
            a2 = s[3-c][1];
            a3 = s[3-c][0];
            o[3-c][3] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[3-c][2] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[3-c][1] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[3-c][0] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_expand_step(input logic [127:0] rk,
                                                     input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = rk;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

endpackage

// File: rtl/aes_enc_round.sv
// One combinational AES encryption round; the final round skips MixColumns.
module aes_enc_round
    import aes_pkg::*;
(
    input  state_t       i_state,
    input  logic [127:0] i_rk,
    input  logic         i_last,
    output state_t       o_state
);

    state_t w_sr;
    state_t w_mc;

    always_comb begin
        w_sr    = shift_rows(sub_bytes(i_state));
        w_mc    = i_last ? w_sr : mix_columns(w_sr);
        o_state = w_mc ^ i_rk;
    end

endmodule

// File: rtl/aes128_ctr_encipher.sv
// Iterative AES-128 CTR encipher: one round per clock, keys expanded on the fly.
// Defining AES_ECB_MODE_EN adds an ecb input that bypasses the counter block.
module aes128_ctr_encipher
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              first,
`ifdef AES_ECB_MODE_EN
    input  logic              ecb,
`endif
    input  logic [63:0]       Iv,
    input  logic [32*Nk-1:0]  key,
    input  logic [32*Nb-1:0]  plain_text,
    output logic [32*Nb-1:0]  cipher,
    output logic              ready
);

    aes_fsm_e     r_fsm, w_fsm_next;
    logic [63:0]  r_iv, r_ctr, r_ctr_used;
    logic [127:0] r_key, r_pt, r_rk, r_cipher;
    state_t       r_state;
    logic [3:0]   r_round;
    logic         r_ready;

    logic         w_accept, w_ecb, w_last;
    logic [63:0]  w_ctr_base;
    logic [127:0] w_init_blk, w_rk_next;
    state_t       w_round_out;

`ifdef AES_ECB_MODE_EN
    logic r_ecb;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ecb <= 1'b0;
        end else if (w_accept) begin
            r_ecb <= ecb;
        end
    end
    assign w_ecb = r_ecb;
`else
    assign w_ecb = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm <= StIdle;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        w_accept   = 1'b0;
        unique case (r_fsm)
            StIdle: begin
                if (start) begin
                    w_accept   = 1'b1;
                    w_fsm_next = StInit;
                end
            end
            StInit:  w_fsm_next = StRound;
            StRound: begin
                if (w_last) begin
                    w_fsm_next = StDone;
                end
            end
            StDone: begin
                w_accept   = start;
                w_fsm_next = start ? StInit : StIdle;
            end
            default: w_fsm_next = StIdle;
        endcase
    end

    // A start accepted in the DONE cycle must chain from the counter being retired.
    assign w_ctr_base = (r_fsm == StDone && !w_ecb) ? r_ctr_used + 64'd1 : r_ctr;
    assign w_init_blk = w_ecb ? r_pt : {r_iv, r_ctr_used};
    assign w_rk_next  = key_expand_step(r_rk, get_rcon(r_round));
    assign w_last     = (r_round == 4'(Nr));

    aes_enc_round u_round (
        .i_state (r_state),
        .i_rk    (w_rk_next),
        .i_last  (w_last),
        .o_state (w_round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iv       <= '0;
            r_key      <= '0;
            r_pt       <= '0;
            r_ctr      <= '0;
            r_ctr_used <= '0;
            r_state    <= '0;
            r_rk       <= '0;
            r_round    <= '0;
            r_cipher   <= '0;
            r_ready    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_iv       <= Iv;
                r_key      <= key;
                r_pt       <= plain_text;
                r_ctr_used <= first ? 64'd0 : w_ctr_base;
            end
            unique case (r_fsm)
                StInit: begin
                    r_state <= w_init_blk ^ r_key;
                    r_rk    <= r_key;
                    r_round <= 4'd1;
                    r_ready <= 1'b0;
                end
                StRound: begin
                    r_state <= w_round_out;
                    r_rk    <= w_rk_next;
                    r_round <= r_round + 4'd1;
                end
                StDone: begin
                    r_cipher <= w_ecb ? r_state : (r_state ^ r_pt);
                    r_ready  <= 1'b1;
                    if (!w_ecb) begin
                        r_ctr <= r_ctr_used + 64'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cipher = r_cipher;
    assign ready  = r_ready;

endmodule

// File: tb/tb_aes128_ctr_encipher.sv
// Scoreboard bench for aes128_ctr_encipher with an independent GF(2^8)-derived AES model.
module tb_aes128_ctr_encipher;

    localparam logic [127:0] KEY     = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] RT_PT   = 128'h50ff65cf9d6834b1d2003de297a2e26f;
    localparam logic [63:0]  IV      = 64'h2232859645102203;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         first = 1'b0;
    logic [63:0]  Iv = '0;
    logic [127:0] key = '0;
    logic [127:0] plain_text = '0;
    logic [127:0] cipher;
    logic         ready;
`ifdef AES_ECB_MODE_EN
    logic         ecb = 1'b0;
`endif

    always #5 clk = ~clk;

    aes128_ctr_encipher dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first      (first),
`ifdef AES_ECB_MODE_EN
        .ecb        (ecb),
`endif
        .Iv         (Iv),
        .key        (key),
        .plain_text (plain_text),
        .cipher     (cipher),
        .ready      (ready)
    );

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic prev_ready = 1'b0;

    typedef struct {
        logic [127:0] exp;
        int           acc;
        string        tag;
    } sb_t;
    sb_t sb[$];

    logic [7:0] tb_sbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from the multiplicative inverse plus affine map, not from a table.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4)
                         ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] blk);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc = 8'h01;
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tb_sbox[tmp[23:16]], tb_sbox[tmp[15:8]], tb_sbox[tmp[7:0]],
                       tb_sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = tb_sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] ks(input logic [63:0] ctr);
        return aes_ref(KEY, {IV, ctr});
    endfunction

    task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Each rising edge of ready retires the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && ready === 1'b1 && prev_ready !== 1'b1) begin
            check_int("pending_request_at_ready", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                check128(sb[0].tag, cipher, sb[0].exp);
                check_int({sb[0].tag, "_latency"}, cyc - sb[0].acc, 12);
                void'(sb.pop_front());
            end
        end
        prev_ready <= ready;
    end

    task automatic issue(input logic f, input logic [63:0] iv, input logic [127:0] k,
                         input logic [127:0] pt, input logic [127:0] exp, input string tag);
        @(negedge clk);
        start      = 1'b1;
        first      = f;
        Iv         = iv;
        key        = k;
        plain_text = pt;
        sb.push_back('{exp, cyc + 1, tag});
        @(posedge clk);
        #1;
        start      = 1'b0;
        first      = 1'($urandom);
        Iv         = {$urandom, $urandom};
        key        = {$urandom, $urandom, $urandom, $urandom};
        plain_text = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        #1;
        check_int({tag, "_drained"}, sb.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        build_sbox();
        repeat (2) @(negedge clk);
        check128("reset_cipher", cipher, 128'h0);
        check_int("reset_ready", int'(ready), 0);
        check128("model_kat", aes_ref(KEY, FIPS_PT), FIPS_CT);
        rst = 1'b0;

        // Block 0, then block 1 started back-to-back in block 0's DONE cycle.
        issue(1'b1, IV, KEY, 128'h0, ks(64'd0), "ctr_blk0");
        repeat (11) @(negedge clk);
        issue(1'b0, IV, KEY, 128'h0, ks(64'd1), "ctr_blk1");
        drain("chain");

`ifdef AES_ECB_MODE_EN
        ecb = 1'b1;
        issue(1'b0, 64'h0, KEY, FIPS_PT, FIPS_CT, "ecb_kat");
        drain("ecb");
        ecb = 1'b0;
        issue(1'b0, IV, KEY, 128'h0, ks(64'd2), "ctr_after_ecb");
        drain("post_ecb");
`endif

        issue(1'b1, IV, KEY, 128'h0, ks(64'd0), "ctr_reload");
        drain("reload");

        issue(1'b1, IV, KEY, RT_PT, ks(64'd0) ^ RT_PT, "rt_enc");
        drain("rt_enc");
        issue(1'b1, IV, KEY, ks(64'd0) ^ RT_PT, RT_PT, "rt_dec");
        drain("rt_dec");

        force dut.r_ctr = 64'hFFFF_FFFF_FFFF_FFFF;
        issue(1'b0, IV, KEY, RT_PT, ks(64'hFFFF_FFFF_FFFF_FFFF) ^ RT_PT, "wrap_max");
        release dut.r_ctr;
        drain("wrap_max");
        check_int("wrap_no_x", int'($isunknown({cipher, ready})), 0);
        issue(1'b0, IV, KEY, 128'h0, ks(64'd0), "wrap_zero");
        drain("wrap_zero");
        check_int("wrap_zero_no_x", int'($isunknown({cipher, ready})), 0);

        // A start while busy must not disturb the block in flight.
        issue(1'b1, IV, KEY, RT_PT, ks(64'd0) ^ RT_PT, "ignore_inflight");
        repeat (4) @(negedge clk);
        start      = 1'b1;
        first      = 1'b1;
        Iv         = ~IV;
        plain_text = ~RT_PT;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain("ignore");

        issue(1'b1, IV, KEY, FIPS_PT, ks(64'd0) ^ FIPS_PT, "rst_victim");
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check128("async_rst_cipher", cipher, 128'h0);
        check_int("async_rst_ready", int'(ready), 0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (20) @(negedge clk);
        check_int("ready_held_low_after_rst", int'(ready), 0);
        check128("cipher_held_after_rst", cipher, 128'h0);
        issue(1'b0, IV, KEY, 128'h0, ks(64'd0), "ctr_after_rst");
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
